// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants, derived totals and sync windows,
// plus the small helpers shared by the timing generator.
package vga_timing_pkg;

  localparam int CNT_W         = 10;
  localparam int CNT_MAX_TOTAL = 1 << CNT_W;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  // Half-open window test done in int so an end bound of 1024 still works.
  function automatic logic in_window(input cnt_t pos, input int start, input int stop);
    return (int'(pos) >= start) && (int'(pos) < stop);
  endfunction

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Master-clock divider: adv_o is high in the last clock of each CLK_DIV period,
// tick_o is the registered copy, so it coincides with the freshly advanced raster.
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic adv_o,
  output logic tick_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("pixel_tick_gen: CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick_q;

  // With CLK_DIV == 1 the counter is stuck at 0 and adv_o is permanently high.
  assign adv_o = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + 1'b1;
    if (adv_o) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= adv_o;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters advanced once per CLK_DIV master
// clocks, with sync, blanking and coordinates all registered from the same next pixel.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV   = DEF_CLK_DIV,
  parameter int   H_DISPLAY = DEF_H_DISPLAY,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_DISPLAY = DEF_V_DISPLAY,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic             original_clk,
  input  logic             reset_n,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             pixel_tick,
  output logic             frame_start
);

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  if (H_TOTAL > CNT_MAX_TOTAL) begin : g_bad_h_total
    $error("vga_sync_gen: H_TOTAL exceeds the 10-bit pixel counter");
  end
  if (V_TOTAL > CNT_MAX_TOTAL) begin : g_bad_v_total
    $error("vga_sync_gen: V_TOTAL exceeds the 10-bit line counter");
  end

  logic  adv_w;
  logic  tick_w;
  cnt_t  h_q;
  cnt_t  h_d;
  cnt_t  v_q;
  cnt_t  v_d;
  sync_t sync_q;
  sync_t sync_d;
  logic  frame_start_q;
  logic  frame_start_d;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i  (original_clk),
    .rst_ni (reset_n),
    .adv_o  (adv_w),
    .tick_o (tick_w)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (adv_w) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Decode from the next position so every output describes the pixel being loaded.
  always_comb begin
    sync_d.hsync    = sync_level(in_window(h_d, H_SYNC_START, H_SYNC_END), SYNC_POL);
    sync_d.vsync    = sync_level(in_window(v_d, V_SYNC_START, V_SYNC_END), SYNC_POL);
    sync_d.video_on = in_window(h_d, 0, H_DISPLAY) && in_window(v_d, 0, V_DISPLAY);
    frame_start_d   = adv_w && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge original_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q            <= '0;
      v_q            <= '0;
      sync_q.hsync    <= ~SYNC_POL;
      sync_q.vsync    <= ~SYNC_POL;
      sync_q.video_on <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
      if (adv_w) begin
        h_q    <= h_d;
        v_q    <= v_d;
        sync_q <= sync_d;
      end
    end
  end

  assign hsync       = sync_q.hsync;
  assign vsync       = sync_q.vsync;
  assign video_on    = sync_q.video_on;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign pixel_tick  = tick_w;
  assign frame_start = frame_start_q;

endmodule
